// File: rtl/seq_adder_64_pkg.sv
// Shared definitions for the sequential 64-bit adder: datapath width, FSM states
// and the slice-width legality check.
package seq_adder_64_pkg;

  localparam int WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A slice width is usable only if it tiles the datapath exactly.
  function automatic bit chunk_ok(input int chunk);
    return (chunk > 0) && (chunk <= WIDTH) && ((WIDTH % chunk) == 0);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell shared across the arithmetic path.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_adder_64_adder_chunk.sv
// W-bit ripple-carry adder slice built from chained full adder cells.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_s[i]),
      .s    (s[i]),
      .cout (carry_s[i+1])
    );
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/seq_adder_64.sv
// Multi-cycle 64-bit adder: one CHUNK-bit ripple slice per clock with a carry
// register between slices, Y-86 style flags, and valid/ready on both sides.
module seq_adder_64
  import seq_adder_64_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] S,
  output logic        cout,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (!chunk_ok(CHUNK)) begin : g_chunk_check
    $error("seq_adder_64: CHUNK must divide 64");
  end

  state_e             state_r, state_next_s;
  logic [WIDTH-1:0]   a_r, b_r, work_r, work_next_s;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   s_r;
  logic               cout_r, zf_r, sf_r, of_r;
  logic [CHUNK-1:0]   slice_a_s, slice_b_s, slice_sum_s;
  logic               slice_cout_s;
  logic               last_s;

  assign slice_a_s = a_r[int'(idx_r)*CHUNK +: CHUNK];
  assign slice_b_s = b_r[int'(idx_r)*CHUNK +: CHUNK];
  assign last_s    = (idx_r == LAST_IDX);

  adder_chunk #(.W(CHUNK)) u_chunk (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Working sum with the current slice merged in; on the last slice this is the full result.
  always_comb begin
    work_next_s = work_r;
    work_next_s[int'(idx_r)*CHUNK +: CHUNK] = slice_sum_s;
  end

  // Next-state logic for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = ADD;
        else          state_next_s = IDLE;
      end
      ADD: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = ADD;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Operand capture, slice accumulation and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      zf_r    <= 1'b0;
      sf_r    <= 1'b0;
      of_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= A;
            b_r     <= B;
            work_r  <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
          end
        end
        ADD: begin
          work_r  <= work_next_s;
          carry_r <= slice_cout_s;
          idx_r   <= idx_r + IDX_W'(1);
          // Results are published only once the final slice lands, never partially.
          if (last_s) begin
            s_r    <= work_next_s;
            cout_r <= slice_cout_s;
            zf_r   <= (work_next_s == '0);
            sf_r   <= work_next_s[WIDTH-1];
            of_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (work_next_s[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign S         = s_r;
  assign cout      = cout_r;
  assign zf        = zf_r;
  assign sf        = sf_r;
  assign of        = of_r;

endmodule

// File: tb/tb_seq_adder_64.sv
// Randomized self-checking bench: three adders (CHUNK 8, 1, 64) run in lockstep
// against an arithmetic reference model.
module tb_seq_adder_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [63:0] a, b;
  logic [2:0]  in_ready, out_valid, cout, zf, sf, of;
  logic [63:0] s [3];
  int          errors = 0;
  int          checks = 0;
  int          lat [3];

  always #5 clk = ~clk;

  seq_adder_64 #(.CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .A(a), .B(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .S(s[0]), .cout(cout[0]), .zf(zf[0]), .sf(sf[0]), .of(of[0]));

  seq_adder_64 #(.CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .A(a), .B(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .S(s[1]), .cout(cout[1]), .zf(zf[1]), .sf(sf[1]), .of(of[1]));

  seq_adder_64 #(.CHUNK(64)) u_c64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .A(a), .B(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .S(s[2]), .cout(cout[2]), .zf(zf[2]), .sf(sf[2]), .of(of[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 65-bit sum gives S and carry; flags from the sign rules.
  function automatic logic [67:0] model(input logic [63:0] av, input logic [63:0] bv);
    logic [64:0] t;
    logic [63:0] sum;
    t   = {1'b0, av} + {1'b0, bv};
    sum = t[63:0];
    return {t[64], (sum == 64'd0), sum[63], (av[63] == bv[63]) && (sum[63] != av[63]), sum};
  endfunction

  task automatic chk_result(input int k, input string tag, input logic [67:0] e);
    chk($sformatf("%s.c%0d.S", tag, k), s[k], e[63:0]);
    chk($sformatf("%s.c%0d.cout_zf_sf_of", tag, k),
        {60'd0, cout[k], zf[k], sf[k], of[k]}, {60'd0, e[67:64]});
  endtask

  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv, input bit stall);
    logic [67:0] e;
    logic [2:0]  seen, fin;
    int          ret [3];
    int          edges;
    e = model(av, bv);
    edges = 0;
    while (in_ready != 3'b111 && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
    chk({tag, ".idle"}, {61'd0, in_ready}, 64'd7);
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = !stall;
    @(posedge clk); #1;
    chk({tag, ".in_ready_fall"}, {61'd0, in_ready}, 64'd0);
    in_valid = stall;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    seen = 3'b000; fin = 3'b000; edges = 0;
    while (fin != 3'b111 && edges < 100) begin
      @(posedge clk); #1; edges++;
      if (stall) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      for (int k = 0; k < 3; k++) begin
        if (!stall && seen[k] && !fin[k] && edges == ret[k]) begin
          chk($sformatf("%s.c%0d.retire", tag, k), {62'd0, in_ready[k], out_valid[k]}, 64'd2);
          fin[k] = 1'b1;
        end
        if (out_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          ret[k]  = edges + 1;
          chk($sformatf("%s.c%0d.latency", tag, k), 64'(edges), 64'(lat[k]));
          chk_result(k, tag, e);
          if (stall) fin[k] = 1'b1;
        end
      end
    end
    if (fin != 3'b111) chk({tag, ".timeout"}, {61'd0, fin}, 64'd7);
    if (stall) begin
      repeat (5) begin
        @(posedge clk); #1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        chk({tag, ".stall_rdy_vld"}, {58'd0, in_ready, out_valid}, 64'd7);
        for (int k = 0; k < 3; k++) chk_result(k, {tag, ".hold"}, e);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".release_rdy_vld"}, {58'd0, in_ready, out_valid}, 64'd56);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".rdy_vld"}, {58'd0, in_ready, out_valid}, 64'd56);
    for (int k = 0; k < 3; k++) chk_result(k, tag, 68'd0);
  endtask

  initial begin
    lat[0] = 8; lat[1] = 64; lat[2] = 1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 64'd0; b = 64'd0;
    repeat (3) @(posedge clk);
    #1 chk_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;

    run_op("basic",   64'h36, 64'h2E, 1'b0);
    run_op("wrap",    64'hFFFF_FFFF_FFFF_FFFF, 64'hA, 1'b0);
    run_op("zero_of", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    run_op("pos_of",  64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op("neg_one", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op($sformatf("rand%0d", i), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    run_op("stall", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

    // Abort a long add mid-flight with an asynchronous reset.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midadd_reset");
    repeat (2) @(posedge clk);
    #1 chk_reset_state("midadd_hold");
    @(negedge clk) rst_n = 1'b1;
    run_op("after_reset", 64'd1, 64'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_adder_64.md
# seq_adder_64

Multi-cycle 64-bit two's-complement adder that computes S = A + B with a CHUNK-bit ripple slice per clock, carrying between slices in a register. It complements the combinational 64-bit subtractor in the execute-stage arithmetic path. It gives the pipeline an area-lean add path with the Y-86 condition-code flags (ZF, SF, OF) and carry-out. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- CHUNK, 8, bits added per cycle; must divide 64 (legal: 1, 2, 4, 8, 16, 32, 64)
- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands A, B are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  64  augend
- B  input  64  addend
- out_valid  output  1  S and flags are valid
- out_ready  input  1  consumer takes the result
- S  output  64  sum A + B, modulo 2^64
- cout  output  1  carry out of bit 63
- zf  output  1  S == 0
- sf  output  1  S[63]
- of  output  1  signed overflow: A[63] == B[63] and S[63] != A[63]

## Operation
- The FSM has three states: IDLE, ADD and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid, latch A and B, clear the carry, set idx=0 and go to ADD.
- **ADD**
  - Each cycle, add slice [idx*CHUNK +: CHUNK] of A and B plus the carry register.
  - Write the sum into the S register slice and store the slice carry-out.
  - idx increments each cycle.
  - On the last slice (idx = 64/CHUNK − 1), set cout from the final carry, compute zf/sf/of from the completed S, and go to DONE.
- **DONE**
  - out_valid=1; S and the flags are held stable.
  - On out_ready, go to IDLE.
- Operands are registered on acceptance. Changes on A and B after the handshake are ignored.
- Inputs are not accepted in ADD or DONE (in_ready=0). in_valid is ignored there.
- On reset (asynchronous, any state, including mid-ADD), the operation is aborted:
  - state=IDLE, in_ready=1.
  - out_valid=0; S, cout, zf, sf and of all =0.
  - Carry and idx are cleared.
  - No partial result is ever presented.
- Results wrap modulo 2^64. The carry is not folded back.

## Timing
- Call the accepting rising edge E0.
- The ADD phase runs for N = 64/CHUNK edges, E1..EN. out_valid rises immediately after EN.
  - CHUNK=8 gives N=8.
  - CHUNK=64 gives N=1, a single-cycle add.
- in_ready falls immediately after E0.
- Throughput is one operation per N+2 cycles minimum: accept, N adds, then 1 cycle in DONE with out_ready=1.
- DONE with out_ready=1 at edge Ek: out_valid falls after Ek and in_ready rises after Ek. There is no same-edge accept-and-retire.
- A DONE stall (out_ready=0) holds out_valid and all outputs indefinitely.
- All outputs are registered. There is no combinational path from inputs to outputs; in_ready depends only on state.

## Structure
- Shared package contents:
  - WIDTH=64 constant.
  - State enum {IDLE, ADD, DONE}.
  - A CHUNK legality check function for divisibility.
- One sub-module, adder_chunk: a CHUNK-bit ripple adder built from the existing fulladder cell (inputs a, b, cin; outputs s, cout).
- The FSM, index counter, carry register and flag logic sit in the top module.

## Test plan
- **Basic add:** A=0x36, B=0x2E, out_ready=1.
  - S=0x64; cout=0, zf=0, sf=0, of=0.
  - out_valid is first seen 8 cycles after accept (CHUNK=8).
- **Carry wrap:** A=0xFFFF_FFFF_FFFF_FFFF, B=0xA.
  - S=0x9; cout=1, zf=0, sf=0, of=0.
- **Zero with overflow:** A=B=0x8000_0000_0000_0000.
  - S=0; cout=1, zf=1, sf=0, of=1.
- **Positive overflow:** A=B=0x4000_0000_0000_0000.
  - S=0x8000_0000_0000_0000; cout=0, sf=1, of=1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid, with A and B toggling and in_valid=1 throughout.
  - S and the flags stay stable; in_ready stays 0.
  - After out_ready, in_ready returns 1 the next cycle.
- **Reset mid-ADD:** assert rst_n=0 asynchronously at idx=3, then release and issue A=1, B=1.
  - During reset: all outputs 0, in_ready=1.
  - Afterwards: S=0x2 with no residue from the aborted operation.
  - Repeat the run with CHUNK=1 and CHUNK=64.
